// File: rtl/stack_port_arb.sv
// Port A arbiter for the two-port stack RAM: the core has fixed priority, and a starvation
// counter guarantees the debug unit a slot. Reads respond one cycle after the grant; out-of-range accesses are flagged.
module stack_port_arb #(
  parameter int unsigned RAM_DEPTH  = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wr,
  input  logic [31:0] ram_rdata
);

  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] DEPTH      = 32'(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, RESP_CORE, RESP_DBG} resp_state_t;

  resp_state_t state;
  logic        was_read;
  logic        oob;
  logic [3:0]  starve_cnt;

  logic        core_win;
  logic        dbg_win;
  logic        win_we;
  logic        win_in_range;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

  always_comb begin
    core_win     = !rst && core_req && !(dbg_req && (starve_cnt == STARVE_LIM));
    dbg_win      = !rst && dbg_req && !core_win;
    win_we       = 1'b0;
    win_addr     = '0;
    win_wdata    = '0;
    if (core_win) begin
      win_we    = core_we;
      win_addr  = core_addr;
      win_wdata = core_wdata;
    end else if (dbg_win) begin
      win_we    = dbg_we;
      win_addr  = dbg_addr;
      win_wdata = dbg_wdata;
    end
    win_in_range = (win_addr < DEPTH);
  end

  assign core_gnt  = core_win;
  assign dbg_gnt   = dbg_win;
  assign ram_addr  = win_addr;
  assign ram_wdata = win_wdata;
  assign ram_wr    = (core_win || dbg_win) && win_we && win_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      state      <= IDLE;
      was_read   <= 1'b0;
      oob        <= 1'b0;
    end else begin
      if (dbg_req && !dbg_win)
        starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;

      // In-range writes need no response slot; everything else answers next cycle.
      if ((core_win || dbg_win) && (!win_we || !win_in_range)) begin
        state    <= core_win ? RESP_CORE : RESP_DBG;
        was_read <= !win_we;
        oob      <= !win_in_range;
      end else begin
        state    <= IDLE;
        was_read <= 1'b0;
        oob      <= 1'b0;
      end
    end
  end

  // Gating with rst drops a response whose slot coincides with reset.
  always_comb begin
    core_rvalid = !rst && (state == RESP_CORE) && was_read;
    core_err    = !rst && (state == RESP_CORE) && oob;
    dbg_rvalid  = !rst && (state == RESP_DBG) && was_read;
    dbg_err     = !rst && (state == RESP_DBG) && oob;
    core_rdata  = (core_rvalid && !oob) ? ram_rdata : 32'd0;
    dbg_rdata   = (dbg_rvalid && !oob) ? ram_rdata : 32'd0;
  end

endmodule

// File: tb/tb_stack_port_arb.sv
// Bench for stack_port_arb: a vector table, hand-written starvation and reset sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_stack_port_arb;
  localparam int DEPTH = 64;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_gnt, core_rvalid, core_err;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_wr;
  logic [31:0] ram_rdata = 32'd0;

  logic [31:0] ram_mem [DEPTH] = '{default: 32'd0};

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  stack_port_arb #(.RAM_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr(ram_wr), .ram_rdata(ram_rdata)
  );

  // Synchronous stack RAM, one-cycle registered read.
  always @(posedge clk) begin
    if (ram_wr && ram_addr < DEPTH) ram_mem[ram_addr[5:0]] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr[5:0]];
  end

  typedef struct {
    logic rst, cr, cw; logic [31:0] ca, cd;
    logic dr, dw;      logic [31:0] da, dd;
    logic gc, gd, wr;
    logic crv; logic [31:0] crd; logic cerr;
    logic drv; logic [31:0] drd; logic derr;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst = r; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #2;
  endtask

  // Reference model state
  int          starve;
  bit          pend_v, pend_core, pend_read, pend_oob;
  logic [31:0] pend_data;
  logic [31:0] shadow [DEPTH];

  initial begin
    rst = 1'b1; core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

    //          rst cr cw ca           cd            dr dw da  dd        gc gd wr crv crd          cerr drv drd      derr
    tbl[0]  = '{1, 1, 1, 32'h10,       32'h1,        1, 0, 0,  0,        0, 0, 0, 0, 0,           0,   0, 0,        0};
    tbl[1]  = '{0, 1, 1, 32'h10,       32'hDEADBEEF, 0, 0, 0,  0,        1, 0, 1, 0, 0,           0,   0, 0,        0};
    tbl[2]  = '{0, 1, 0, 32'h10,       0,            0, 0, 0,  0,        1, 0, 0, 0, 0,           0,   0, 0,        0};
    tbl[3]  = '{0, 1, 1, 32'h1,        32'hA,        0, 0, 0,  0,        1, 0, 1, 1, 32'hDEADBEEF,0,   0, 0,        0};
    tbl[4]  = '{0, 1, 1, 32'h2,        32'hB,        0, 0, 0,  0,        1, 0, 1, 0, 0,           0,   0, 0,        0};
    tbl[5]  = '{0, 1, 1, 32'h3,        32'hC,        0, 0, 0,  0,        1, 0, 1, 0, 0,           0,   0, 0,        0};
    tbl[6]  = '{0, 1, 0, 32'h1,        0,            0, 0, 0,  0,        1, 0, 0, 0, 0,           0,   0, 0,        0};
    tbl[7]  = '{0, 1, 0, 32'h2,        0,            0, 0, 0,  0,        1, 0, 0, 1, 32'hA,       0,   0, 0,        0};
    tbl[8]  = '{0, 1, 0, 32'h3,        0,            0, 0, 0,  0,        1, 0, 0, 1, 32'hB,       0,   0, 0,        0};
    tbl[9]  = '{0, 0, 0, 0,            0,            1, 1, 63, 32'h1234, 0, 1, 1, 1, 32'hC,       0,   0, 0,        0};
    tbl[10] = '{0, 0, 0, 0,            0,            1, 1, 64, 32'h55,   0, 1, 0, 0, 0,           0,   0, 0,        0};
    tbl[11] = '{0, 0, 0, 0,            0,            1, 0, 63, 0,        0, 1, 0, 0, 0,           0,   0, 0,        1};
    tbl[12] = '{0, 1, 1, 32'h20,       32'h77,       0, 0, 0,  0,        1, 0, 1, 0, 0,           0,   1, 32'h1234, 0};
    tbl[13] = '{0, 0, 0, 0,            0,            1, 0, 32, 0,        0, 1, 0, 0, 0,           0,   0, 0,        0};
    tbl[14] = '{0, 1, 0, 32'hFFFFFFFF, 0,            0, 0, 0,  0,        1, 0, 0, 0, 0,           0,   1, 32'h77,   0};
    tbl[15] = '{0, 1, 1, 32'h5,        32'h99,       1, 0, 6,  0,        1, 0, 1, 1, 0,           1,   0, 0,        0};
    tbl[16] = '{0, 0, 0, 0,            0,            0, 0, 0,  0,        0, 0, 0, 0, 0,           0,   0, 0,        0};
    tbl[17] = '{0, 0, 0, 0,            0,            0, 0, 0,  0,        0, 0, 0, 0, 0,           0,   0, 0,        0};

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
            tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      check($sformatf("tbl%0d core_gnt", i), 32'(core_gnt), 32'(tbl[i].gc));
      check($sformatf("tbl%0d dbg_gnt", i), 32'(dbg_gnt), 32'(tbl[i].gd));
      check($sformatf("tbl%0d ram_wr", i), 32'(ram_wr), 32'(tbl[i].wr));
      check($sformatf("tbl%0d core_rvalid", i), 32'(core_rvalid), 32'(tbl[i].crv));
      check($sformatf("tbl%0d core_rdata", i), core_rdata, tbl[i].crd);
      check($sformatf("tbl%0d core_err", i), 32'(core_err), 32'(tbl[i].cerr));
      check($sformatf("tbl%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(tbl[i].drv));
      check($sformatf("tbl%0d dbg_rdata", i), dbg_rdata, tbl[i].drd);
      check($sformatf("tbl%0d dbg_err", i), 32'(dbg_err), 32'(tbl[i].derr));
    end

    // Continuous contention: core 4 grants, debug 1, repeating.
    for (int i = 0; i < 16; i++) begin
      bit on;
      on = (i < 15);
      drive(0, on, 0, 32'h1, 0, on, 0, 32'h2, 0);
      check($sformatf("starve%0d core_gnt", i), 32'(core_gnt), 32'(on && (i % 5 != 4)));
      check($sformatf("starve%0d dbg_gnt", i), 32'(dbg_gnt), 32'(on && (i % 5 == 4)));
      check($sformatf("starve%0d core_rvalid", i), 32'(core_rvalid), 32'(i > 0 && ((i - 1) % 5 != 4)));
      check($sformatf("starve%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(i > 0 && ((i - 1) % 5 == 4)));
      if (i > 0 && ((i - 1) % 5 == 4)) begin
        check($sformatf("starve%0d dbg_rdata", i), dbg_rdata, 32'hB);
        check($sformatf("starve%0d starve_cnt", i), 32'(dut.starve_cnt), 32'd0);
      end else if (i > 0) begin
        check($sformatf("starve%0d core_rdata", i), core_rdata, 32'hA);
      end
    end

    // Reset lands on the response slot of a granted read.
    drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    check("rstmid grant", 32'(core_gnt), 32'd1);
    drive(1, 1, 0, 32'h10, 0, 1, 0, 32'h2, 0);
    check("rstmid core_gnt", 32'(core_gnt), 32'd0);
    check("rstmid dbg_gnt", 32'(dbg_gnt), 32'd0);
    check("rstmid ram_wr", 32'(ram_wr), 32'd0);
    check("rstmid core_rvalid", 32'(core_rvalid), 32'd0);
    check("rstmid core_err", 32'(core_err), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rstpost core_rvalid", 32'(core_rvalid), 32'd0);
    check("rstpost core_err", 32'(core_err), 32'd0);
    check("rstpost starve_cnt", 32'(dut.starve_cnt), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rstpost2 core_rvalid", 32'(core_rvalid), 32'd0);

    // Randomized traffic against the reference model; start from reset and the RAM's current contents.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) shadow[i] = ram_mem[i];
    starve = 0; pend_v = 0; pend_core = 0; pend_read = 0; pend_oob = 0; pend_data = 0;

    for (int n = 0; n < 3000; n++) begin
      logic r, cr, cw, dr, dw, cwin, dwin, we, inr, ewr;
      logic [31:0] ca, cd, da, dd, waddr, wdata;
      int sel;
      r  = ($urandom_range(0, 63) == 0);
      cr = ($urandom_range(0, 2) != 0);
      dr = ($urandom_range(0, 2) != 0);
      cw = $urandom_range(0, 1);
      dw = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      ca = (sel == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : (sel == 1) ? 32'd64 : 32'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
      da = (sel == 0) ? 32'd65 : (sel == 1) ? 32'd63 : 32'($urandom_range(0, 15));
      cd = $urandom; dd = $urandom;
      drive(r, cr, cw, ca, cd, dr, dw, da, dd);

      cwin = !r && cr && !(dr && starve == SMAX);
      dwin = !r && dr && !cwin;
      we    = cwin ? cw : dwin ? dw : 1'b0;
      waddr = cwin ? ca : dwin ? da : 32'd0;
      wdata = cwin ? cd : dwin ? dd : 32'd0;
      inr   = (waddr < DEPTH);
      ewr   = (cwin || dwin) && we && inr;

      check("rnd core_gnt", 32'(core_gnt), 32'(cwin));
      check("rnd dbg_gnt", 32'(dbg_gnt), 32'(dwin));
      check("rnd ram_wr", 32'(ram_wr), 32'(ewr));
      check("rnd ram_addr", ram_addr, waddr);
      check("rnd ram_wdata", ram_wdata, wdata);
      check("rnd core_rvalid", 32'(core_rvalid), 32'(!r && pend_v && pend_core && pend_read));
      check("rnd core_err", 32'(core_err), 32'(!r && pend_v && pend_core && pend_oob));
      check("rnd core_rdata", core_rdata, (!r && pend_v && pend_core && pend_read) ? pend_data : 32'd0);
      check("rnd dbg_rvalid", 32'(dbg_rvalid), 32'(!r && pend_v && !pend_core && pend_read));
      check("rnd dbg_err", 32'(dbg_err), 32'(!r && pend_v && !pend_core && pend_oob));
      check("rnd dbg_rdata", dbg_rdata, (!r && pend_v && !pend_core && pend_read) ? pend_data : 32'd0);

      if (r) begin
        starve = 0;
        pend_v = 0;
      end else begin
        starve    = (dr && !dwin) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        pend_v    = (cwin || dwin) && (!we || !inr);
        pend_core = cwin;
        pend_read = !we;
        pend_oob  = !inr;
        pend_data = (inr && !we) ? shadow[waddr[5:0]] : 32'd0;
        if (ewr) shadow[waddr[5:0]] = wdata;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
